// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: sequencer state encoding and default sizes.
package i2s_pkg;

  localparam int WSZ_DEF   = 32;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with flush, fill level, full/empty and a drop strobe.
module sync_fifo #(
  parameter  int WSZ   = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_wr,
  input  logic [WSZ-1:0] i_wdata,
  input  logic           i_rd,
  output logic [WSZ-1:0] o_rdata,
  output logic           o_empty,
  output logic           o_full,
  output logic [AW:0]    o_level,
  output logic           o_drop
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WSZ-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  // A pop on an empty FIFO is ignored, so a simultaneous push alone is accepted.
  assign w_pop   = i_rd & ~w_empty;
  assign w_push  = i_wr & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_level;
  assign o_drop  = i_wr & w_full & ~w_pop & ~i_flush;

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive sequencer: bit-tick generation, start-up sample discard, sample capture
// into a FIFO, sticky overflow and a threshold level interrupt.
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter  int WSZ   = WSZ_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           cfg_mode,
  input  logic [15:0]    cfg_presc,
  input  logic [7:0]     cfg_warmup,
  input  logic [AW:0]    cfg_thresh,
  input  logic           flush,
  input  logic           ovf_clr,
  input  logic [WSZ-1:0] i2s_sample,
  input  logic           i2s_rdy,
  output logic           i2s_tick,
  output logic           i2s_mode,
  input  logic           fifo_rd,
  output logic [WSZ-1:0] fifo_rdata,
  output logic           fifo_empty,
  output logic           fifo_full,
  output logic [AW:0]    fifo_level,
  output logic           irq,
  output logic           ovf,
  output logic           busy
);

  rx_state_t   r_state;
  rx_state_t   w_next;
  logic [15:0] r_tcnt;
  logic [7:0]  r_wcnt;
  logic        r_rdy_q;
  logic        r_mode;
  logic        r_irq;
  logic        r_ovf;

  logic        w_cap;
  logic        w_busy;
  logic        w_run;
  logic        w_warm;
  logic        w_tick;
  logic        w_warm_done;
  logic        w_push;
  logic        w_drop;
  logic [AW:0] w_level;

  assign w_cap       = i2s_rdy & ~r_rdy_q;
  assign w_warm_done = ({1'b0, r_wcnt} + 9'd1) >= {1'b0, cfg_warmup};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) w_next = (cfg_warmup != 8'd0) ? ST_WARMUP : ST_RUN;
      end
      ST_WARMUP: begin
        if (!en)                     w_next = ST_IDLE;
        else if (w_cap && w_warm_done) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (!en) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_run  = 1'b0;
    w_warm = 1'b0;
    case (r_state)
      ST_WARMUP: begin
        w_busy = 1'b1;
        w_warm = 1'b1;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        w_run  = 1'b1;
      end
      default: ;
    endcase
    w_tick = w_busy & (r_tcnt == cfg_presc);
  end

  // The >= wrap keeps the divider sane if cfg_presc shrinks below the running count.
  always_ff @(posedge clk) begin
    if (rst || !w_busy)         r_tcnt <= '0;
    else if (r_tcnt >= cfg_presc) r_tcnt <= '0;
    else                          r_tcnt <= r_tcnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || !w_warm) r_wcnt <= '0;
    else if (w_cap)     r_wcnt <= r_wcnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy_q <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_rdy_q <= i2s_rdy;
      r_mode  <= cfg_mode;
    end
  end

  assign w_push = w_cap & w_run;

  sync_fifo #(
    .WSZ   (WSZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_wr    (w_push),
    .i_wdata (i2s_sample),
    .i_rd    (fifo_rd),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  // A fresh drop wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      r_irq <= (cfg_thresh != '0) && (w_level >= cfg_thresh);
    end
  end

  assign i2s_tick   = w_tick;
  assign i2s_mode   = r_mode;
  assign fifo_level = w_level;
  assign irq        = r_irq;
  assign ovf        = r_ovf;
  assign busy       = w_busy;

endmodule
